// File: rtl/fp_pkg.sv
// Shared binary32 constants, FSM state encoding and operand classification
// for the FP arithmetic cluster (multiplier and divider).
package fp_pkg;

    localparam int unsigned MANT_W   = 24;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t MUL  = 2'd1;
    localparam state_t NORM = 2'd2;
    localparam state_t DONE = 2'd3;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Denormals classify as zero (DAZ).
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.zero = (x[30:23] == 8'h00);
        c.inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'h0);
        c.nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'h0);
        return c;
    endfunction

endpackage

// File: rtl/float_multiplier_seq_if.sv
// Operand/result handshake bundle of the sequential float multiplier.
interface float_multiplier_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        error;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, error, overflow, underflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, error, overflow, underflow
    );

endinterface

// File: rtl/float_multiplier_seq_mantissa_mult_seq.sv
// 24-step shift-add mantissa multiplier: one partial product per cycle,
// last_step flags the cycle in which the final partial product is added.
module mantissa_mult_seq
    import fp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MANT_W-1:0]       mant_a,
    input  logic [MANT_W-1:0]       mant_b,
    output logic                    last_step,
    output logic [2*MANT_W-1:0]     product
);

    localparam int unsigned CNT_W = $clog2(MANT_W);

    logic [MANT_W-1:0]   ma_q;
    logic [MANT_W-1:0]   mb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic [2*MANT_W-1:0] acc_q;

    assign last_step = busy_q && (cnt_q == CNT_W'(MANT_W - 1));
    assign product   = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ma_q   <= '0;
            mb_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            acc_q  <= '0;
        end else if (start) begin
            ma_q   <= mant_a;
            mb_q   <= mant_b;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            acc_q  <= '0;
        end else if (busy_q) begin
            if (mb_q[cnt_q]) begin
                acc_q <= acc_q + ({{MANT_W{1'b0}}, ma_q} << cnt_q);
            end
            cnt_q <= last_step ? '0 : cnt_q + 1'b1;
            if (last_step) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/float_multiplier_seq.sv
// Sequential binary32 multiplier: special cases resolve in one cycle, normal
// operands go through the shift-add engine, a one-cycle normalise, then DONE.
module float_multiplier_seq
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    float_multiplier_seq_if.slave bus
);

    state_t      state;
    logic        sign_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [31:0] result_q;
    logic        error_q;
    logic        overflow_q;
    logic        underflow_q;

    logic        mult_start;
    logic        mult_last;
    logic [47:0] product;
    logic        unused_lsbs;

    fp_class_t   ca;
    fp_class_t   cb;
    logic        in_sign;
    logic        spec_hit;
    logic        spec_err;
    logic [31:0] spec_result;

    logic signed [9:0] exp_sum;
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_mant;
    logic              norm_ov;
    logic              norm_un;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.error     = error_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    assign unused_lsbs = ^product[22:0];

    always_comb begin
        ca          = classify(bus.a);
        cb          = classify(bus.b);
        in_sign     = bus.a[31] ^ bus.b[31];
        spec_hit    = 1'b1;
        spec_err    = 1'b0;
        spec_result = '0;
        if (ca.nan || cb.nan || (ca.zero && cb.inf) || (ca.inf && cb.zero)) begin
            spec_err    = 1'b1;
            spec_result = QNAN;
        end else if (ca.inf || cb.inf) begin
            spec_result = {in_sign, EXP_MAX, 23'h0};
        end else if (ca.zero || cb.zero) begin
            spec_result = {in_sign, 31'h0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign mult_start = (state == IDLE) && bus.in_valid && !spec_hit;

    mantissa_mult_seq u_mult (
        .clk       (clk),
        .rst       (rst),
        .start     (mult_start),
        .mant_a    ({1'b1, bus.a[22:0]}),
        .mant_b    ({1'b1, bus.b[22:0]}),
        .last_step (mult_last),
        .product   (product)
    );

    // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the extra shift.
    always_comb begin
        exp_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(10'(EXP_BIAS));
        if (product[47]) begin
            norm_mant = product[46:24];
            norm_exp  = exp_sum + 10'sd1;
        end else begin
            norm_mant = product[45:23];
            norm_exp  = exp_sum;
        end
        norm_ov = (norm_exp >= 10'sd255);
        norm_un = !norm_ov && (norm_exp <= 10'sd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            result_q    <= '0;
            error_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q      <= in_sign;
                        ea_q        <= bus.a[30:23];
                        eb_q        <= bus.b[30:23];
                        result_q    <= spec_result;
                        error_q     <= spec_err;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        state       <= spec_hit ? DONE : MUL;
                    end
                end
                MUL: begin
                    if (mult_last) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    overflow_q  <= norm_ov;
                    underflow_q <= norm_un;
                    if (norm_ov) begin
                        result_q <= {sign_q, EXP_MAX, 23'h0};
                    end else if (norm_un) begin
                        result_q <= {sign_q, 31'h0};
                    end else begin
                        result_q <= {sign_q, norm_exp[7:0], norm_mant};
                    end
                    state <= DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_multiplier_seq.sv
// Self-checking bench for float_multiplier_seq: directed vector table, random
// operands against an arithmetic reference model, backpressure and mid-op reset.
module tb_float_multiplier_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_multiplier_seq_if bus ();

    float_multiplier_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        logic        ov;
        logic        un;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer product of the hidden-bit mantissas.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        logic             s;
        logic             za, zb, ia, ib, na, nb;
        longint unsigned  p;
        int               e;
        longint unsigned  m;
        v.a = a; v.b = b; v.err = 0; v.ov = 0; v.un = 0; v.lat = 1;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 0);   zb = (b[30:23] == 0);
        ia = (a[30:23] == 255) && (a[22:0] == 0);
        ib = (b[30:23] == 255) && (b[22:0] == 0);
        na = (a[30:23] == 255) && (a[22:0] != 0);
        nb = (b[30:23] == 255) && (b[22:0] != 0);
        if (na || nb || (za && ib) || (ia && zb)) begin
            v.res = 32'h7FC0_0000; v.err = 1;
        end else if (ia || ib) begin
            v.res = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            v.res = {s, 31'h0};
        end else begin
            v.lat = 26;
            p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            if (p >= (64'd1 << 47)) begin
                m = (p >> 24) & 64'h7F_FFFF;
                e = e + 1;
            end else begin
                m = (p >> 23) & 64'h7F_FFFF;
            end
            if (e >= 255) begin
                v.res = {s, 8'hFF, 23'h0}; v.ov = 1;
            end else if (e <= 0) begin
                v.res = {s, 31'h0}; v.un = 1;
            end else begin
                v.res = {s, e[7:0], m[22:0]};
            end
        end
        return v;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output vec_t r);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        r.lat = 1;
        while (!bus.out_valid && r.lat < 100) begin
            @(posedge clk); #1; r.lat++;
        end
        r.a = a; r.b = b;
        r.res = bus.result; r.err = bus.error; r.ov = bus.overflow; r.un = bus.underflow;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp);
        check({tag, " result"}, got.res, exp.res);
        check({tag, " flags"}, {29'b0, got.err, got.ov, got.un}, {29'b0, exp.err, exp.ov, exp.un});
        check({tag, " latency"}, 32'(got.lat), 32'(exp.lat));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        int k;
        x = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0)      x[30:23] = 8'h00;
        else if (k == 1) x[30:23] = 8'hFF;
        else if (k == 2) x[22:0]  = 23'h0;
        else             x[30:23] = 8'($urandom_range(1, 254));
        return x;
    endfunction

    vec_t vecs[$];
    vec_t got;
    vec_t exp;
    int   seen;

    initial begin
        vecs.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 26});
        vecs.push_back('{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 26});
        vecs.push_back('{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 26});
        vecs.push_back('{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 26});
        vecs.push_back('{32'h0080_0000, 32'hBF80_0000, 32'h8080_0000, 1'b0, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h3FC0_0000, 32'h00C0_0000, 32'h0110_0000, 1'b0, 1'b0, 1'b0, 26});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1});

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset flags", {29'b0, bus.error, bus.overflow, bus.underflow}, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, got);
            compare($sformatf("vec%0d", i), got, vecs[i]);
        end

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = rand_operand();
            rb = rand_operand();
            exp = model(ra, rb);
            do_op(ra, rb, got);
            compare($sformatf("rand%0d %h*%h", i, ra, rb), got, exp);
        end

        // Backpressure: result held, new operands ignored while DONE.
        bus.a = 32'h4000_0000; bus.b = 32'h4040_0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        seen = 0;
        while (!bus.out_valid && seen < 100) begin
            @(posedge clk); #1; seen++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.a = 32'h3F80_0000; bus.b = 32'h3F80_0000; bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp result", bus.result, 32'h40C0_0000);
            check("bp flags", {29'b0, bus.error, bus.overflow, bus.underflow}, 32'd0);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp no stray accept", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of MUL discards the operation.
        bus.a = 32'h4000_0000; bus.b = 32'h4040_0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("midreset discarded", 32'(seen), 32'd0);
        do_op(32'h4000_0000, 32'h4040_0000, got);
        compare("after reset 2*3", got, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
